adc_charge_balance: RTL and testbench
=====================================

// Module: adc_charge_balance
// PURPOSE
// - Charge-balance run-up / single-slope run-down integrating ADC sequencer.
// - Consumes the 1-cycle adc_measure_start pulse from the modulation stage upstream.
// - Drives the integrator-reset, signal and reference switches; counts the reference polarity cycles.
// - Returns adc_measure_done plus the latched conversion counts to the modulation stage.
// PARAMETERS
// - RESET_N      5000    clocks integrator-reset switch is held closed (250us @ 20MHz)
// - CYCLE_N      20      clocks per run-up reference cycle (fixed-frequency modulation)
// - APERTURE_N   200000  run-up clocks; rounded up to a whole number of CYCLE_N cycles
// - RUNDOWN_MAX  65535   run-down clock limit before timeout
// PORTS
// - clk                 in   1   system clock, 20MHz
// - reset               in   1   synchronous, active-high
// - adc_measure_start   in   1   1-cycle start pulse
// - comp_in             in   1   integrator comparator, asynchronous; 1 = integrator above zero
// - int_reset           out  1   integrator reset switch, 1 = closed
// - sig_sw              out  1   signal input switch, 1 = connected
// - refmux              out  2   00 = none, 01 = +ref (drives up), 10 = -ref (drives down); 11 never driven
// - adc_measure_done    out  1   1-cycle pulse when results are valid
// - count_up            out  24  run-up cycles with +ref, latched at done
// - count_down          out  24  run-up cycles with -ref, latched at done
// - count_rundown       out  16  run-down clocks, latched at done
// - rundown_sign        out  1   run-down reference used: 1 = -ref
// - timeout             out  1   last run-down hit RUNDOWN_MAX
// - monitor             out  2   [0] = run-up active, [1] = run-down active
// BEHAVIOUR
// - Registered outputs, synchronous reset.
// - Reset values: int_reset=1, sig_sw=0, refmux=00, done=0, all counts and flags 0, monitor=0.
// - Reset applies in any state: switch state is immediately int_reset=1, sig_sw=0, refmux=00; any conversion in progress is abandoned.
// - comp_in passes through a 2-flop synchroniser (comp_s). Decisions use comp_s only.
// - States:
//   - IDLE:
//     - int_reset=1, others off. Start seen in cycle N -> RESET_INT; counter loaded with RESET_N in cycle N+1.
//     - Internal run counters clear.
//   - RESET_INT:
//     - Hold for RESET_N clocks -> RUNUP.
//   - RUNUP:
//     - int_reset=0, sig_sw=1.
//     - At the first clock of each CYCLE_N cycle, sample comp_s:
//       - 1 -> refmux=10 for the whole cycle, down count +1.
//       - 0 -> refmux=01 for the whole cycle, up count +1.
//     - Aperture counter decrements every clock. Exit only at a cycle boundary with aperture<=0 -> RUNDOWN.
//     - up+down = ceil(APERTURE_N/CYCLE_N).
//   - RUNDOWN:
//     - sig_sw=0. Reference polarity is chosen once on entry: comp_s=1 -> 10, else 01; rundown_sign records it.
//     - Count clocks until comp_s differs from its entry value, or the count reaches RUNDOWN_MAX (then timeout=1).
//     - refmux=00 on exit.
//   - DONE:
//     - Latch count_up/count_down/count_rundown/rundown_sign/timeout.
//     - Pulse adc_measure_done for exactly 1 cycle, set int_reset=1, go to IDLE.
// - Overflow: counters saturate at all-ones, never wrap.
// - Start while not IDLE is ignored; no queueing.
// - Start in the same cycle as DONE is also ignored; the upstream stage only restarts after done.
// - Result outputs hold their values until the next DONE. Reset clears them.
// - sig_sw and refmux changes are registered in the same edge. refmux is never 11.
// TESTING (sim params: RESET_N=5, CYCLE_N=10, APERTURE_N=100, RUNDOWN_MAX=50)
// - Reset release, then start pulse -> int_reset falls exactly 5 clocks after RESET_INT entry.
//   - Runs 10 run-up cycles; up+down=10; done pulses once; monitor sequence 01 -> 10 -> 00.
// - comp_in held 0, flips to 1 at 7 clocks into run-down -> count_up=10, count_down=0.
//   - rundown_sign=0; count_rundown=7 plus 2 synchroniser cycles = 9; timeout=0.
// - comp_in alternating every 10 clocks in phase with cycles -> count_up=5, count_down=5.
// - comp_in stuck during run-down -> count_rundown=50, timeout=1; done still pulses.
// - Second start mid-run-up -> ignored; single done; counts equal an undisturbed run.
// - reset asserted mid-run-up -> next clock int_reset=1, sig_sw=0, refmux=00, no done.
//   - Previously latched counts read 0.

Source files
------------

// File: rtl/adc_charge_balance.sv
`default_nettype none
// ============================================================================
// Module   : adc_charge_balance
// Brief    : Charge-balance run-up / single-slope run-down integrating ADC
//            sequencer with saturating cycle counters and latched results.
// Revision : 1.0
// ============================================================================
module adc_charge_balance #(
  parameter int RESET_N     = 5000,
  parameter int CYCLE_N     = 20,
  parameter int APERTURE_N  = 200000,
  parameter int RUNDOWN_MAX = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adc_measure_start_i,
  input  logic        comp_in_i,
  output logic        int_reset_o,
  output logic        sig_sw_o,
  output logic [1:0]  refmux_o,
  output logic        adc_measure_done_o,
  output logic [23:0] count_up_o,
  output logic [23:0] count_down_o,
  output logic [15:0] count_rundown_o,
  output logic        rundown_sign_o,
  output logic        timeout_o,
  output logic [1:0]  monitor_o
);
  localparam int RST_W = $clog2(RESET_N + 1);
  localparam int PH_W  = $clog2(CYCLE_N + 1);
  localparam int AP_W  = $clog2(APERTURE_N + 1) + 1;
  localparam logic [1:0] REF_NONE = 2'b00;
  localparam logic [1:0] REF_POS  = 2'b01;
  localparam logic [1:0] REF_NEG  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET_INT = 3'd1,
    S_RUNUP     = 3'd2,
    S_RUNDOWN   = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              comp_meta_q, comp_s_q;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [AP_W-1:0]   aper_q, aper_d, aper_dec;
  logic [23:0]       up_q, up_d, dn_q, dn_d;
  logic [15:0]       rd_q, rd_d;
  logic              rd_ref_q, rd_ref_d, to_q, to_d;
  logic              int_reset_q, int_reset_d, sig_sw_q, sig_sw_d;
  logic [1:0]        refmux_q, refmux_d, monitor_q, monitor_d;
  logic              done_q, done_d;
  logic [23:0]       count_up_q, count_up_d, count_down_q, count_down_d;
  logic [15:0]       count_rd_q, count_rd_d;
  logic              sign_q, sign_d, timeout_q, timeout_d;
  logic              new_cycle, finish_rd;

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    phase_d      = phase_q;
    aper_d       = aper_q;
    up_d         = up_q;
    dn_d         = dn_q;
    rd_d         = rd_q;
    rd_ref_d     = rd_ref_q;
    to_d         = to_q;
    int_reset_d  = int_reset_q;
    sig_sw_d     = sig_sw_q;
    refmux_d     = refmux_q;
    monitor_d    = monitor_q;
    done_d       = 1'b0;
    count_up_d   = count_up_q;
    count_down_d = count_down_q;
    count_rd_d   = count_rd_q;
    sign_d       = sign_q;
    timeout_d    = timeout_q;
    new_cycle    = 1'b0;
    finish_rd    = 1'b0;
    aper_dec     = aper_q - AP_W'(1);

    case (state_q)
      S_IDLE: begin
        up_d = '0;
        dn_d = '0;
        rd_d = '0;
        to_d = 1'b0;
        if (adc_measure_start_i) begin
          state_d   = S_RESET_INT;
          rst_cnt_d = RST_W'(RESET_N);
        end
      end
      S_RESET_INT: begin
        rst_cnt_d = rst_cnt_q - RST_W'(1);
        if (rst_cnt_q <= RST_W'(1)) begin
          state_d     = S_RUNUP;
          int_reset_d = 1'b0;
          sig_sw_d    = 1'b1;
          monitor_d   = 2'b01;
          phase_d     = '0;
          aper_d      = AP_W'(APERTURE_N);
          new_cycle   = 1'b1;
        end
      end
      S_RUNUP: begin
        aper_d = aper_dec;
        if (phase_q == PH_W'(CYCLE_N - 1)) begin
          phase_d = '0;
          // Aperture is two's complement: exhausted once it reaches zero or below.
          if (aper_dec[AP_W-1] || (aper_dec == '0)) begin
            state_d   = S_RUNDOWN;
            sig_sw_d  = 1'b0;
            monitor_d = 2'b10;
            rd_ref_d  = comp_s_q;
            refmux_d  = comp_s_q ? REF_NEG : REF_POS;
            rd_d      = '0;
          end else begin
            new_cycle = 1'b1;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_RUNDOWN: begin
        if (comp_s_q != rd_ref_q) begin
          finish_rd = 1'b1;
        end else begin
          rd_d = (&rd_q) ? rd_q : rd_q + 16'd1;
          if (rd_q == 16'(RUNDOWN_MAX - 1)) begin
            to_d      = 1'b1;
            finish_rd = 1'b1;
          end
        end
        if (finish_rd) begin
          state_d   = S_DONE;
          refmux_d  = REF_NONE;
          monitor_d = 2'b00;
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        done_d       = 1'b1;
        int_reset_d  = 1'b1;
        count_up_d   = up_q;
        count_down_d = dn_q;
        count_rd_d   = rd_q;
        sign_d       = rd_ref_q;
        timeout_d    = to_q;
      end
      default: begin
        state_d     = S_IDLE;
        int_reset_d = 1'b1;
        sig_sw_d    = 1'b0;
        refmux_d    = REF_NONE;
        monitor_d   = 2'b00;
      end
    endcase

    // Reference polarity for a whole run-up cycle is fixed at its first clock.
    if (new_cycle) begin
      if (comp_s_q) begin
        refmux_d = REF_NEG;
        dn_d     = (&dn_q) ? dn_q : dn_q + 24'd1;
      end else begin
        refmux_d = REF_POS;
        up_d     = (&up_q) ? up_q : up_q + 24'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      comp_meta_q  <= 1'b0;
      comp_s_q     <= 1'b0;
      rst_cnt_q    <= '0;
      phase_q      <= '0;
      aper_q       <= '0;
      up_q         <= '0;
      dn_q         <= '0;
      rd_q         <= '0;
      rd_ref_q     <= 1'b0;
      to_q         <= 1'b0;
      int_reset_q  <= 1'b1;
      sig_sw_q     <= 1'b0;
      refmux_q     <= REF_NONE;
      monitor_q    <= 2'b00;
      done_q       <= 1'b0;
      count_up_q   <= '0;
      count_down_q <= '0;
      count_rd_q   <= '0;
      sign_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      comp_meta_q  <= comp_in_i;
      comp_s_q     <= comp_meta_q;
      rst_cnt_q    <= rst_cnt_d;
      phase_q      <= phase_d;
      aper_q       <= aper_d;
      up_q         <= up_d;
      dn_q         <= dn_d;
      rd_q         <= rd_d;
      rd_ref_q     <= rd_ref_d;
      to_q         <= to_d;
      int_reset_q  <= int_reset_d;
      sig_sw_q     <= sig_sw_d;
      refmux_q     <= refmux_d;
      monitor_q    <= monitor_d;
      done_q       <= done_d;
      count_up_q   <= count_up_d;
      count_down_q <= count_down_d;
      count_rd_q   <= count_rd_d;
      sign_q       <= sign_d;
      timeout_q    <= timeout_d;
    end
  end

  assign int_reset_o        = int_reset_q;
  assign sig_sw_o           = sig_sw_q;
  assign refmux_o           = refmux_q;
  assign monitor_o          = monitor_q;
  assign adc_measure_done_o = done_q;
  assign count_up_o         = count_up_q;
  assign count_down_o       = count_down_q;
  assign count_rundown_o    = count_rd_q;
  assign rundown_sign_o     = sign_q;
  assign timeout_o          = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_charge_balance.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_charge_balance
// Brief    : Randomized self-checking bench for adc_charge_balance against a
//            timeline reference model.
// Revision : 1.0
// ============================================================================
module tb_adc_charge_balance;
  localparam int RESET_N     = 5;
  localparam int CYCLE_N     = 10;
  localparam int APERTURE_N  = 100;
  localparam int RUNDOWN_MAX = 50;
  localparam int NCYC        = (APERTURE_N + CYCLE_N - 1) / CYCLE_N;
  localparam int E_RD        = RESET_N + NCYC * CYCLE_N;
  localparam int M_STEP7     = 0;
  localparam int M_ALT       = 1;
  localparam int M_STUCK     = 2;
  localparam int M_RAND      = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        comp = 1'b0;
  logic        int_reset, sig_sw, done, rundown_sign, timeout;
  logic [1:0]  refmux, monitor;
  logic [23:0] count_up, count_down;
  logic [15:0] count_rundown;

  int checks = 0;
  int errors = 0;

  // comp_arr[t] is what the bench drives on comp_in just after edge t of a run
  // (edge 0 is the one that samples the start pulse).
  bit comp_arr [0:511];
  bit dec      [0:63];
  int m_up, m_dn, m_rd, m_x;
  bit m_ref, m_to;

  adc_charge_balance #(
    .RESET_N(RESET_N), .CYCLE_N(CYCLE_N),
    .APERTURE_N(APERTURE_N), .RUNDOWN_MAX(RUNDOWN_MAX)
  ) u_dut (
    .clk                 (clk),
    .reset               (reset),
    .adc_measure_start_i (start),
    .comp_in_i           (comp),
    .int_reset_o         (int_reset),
    .sig_sw_o            (sig_sw),
    .refmux_o            (refmux),
    .adc_measure_done_o  (done),
    .count_up_o          (count_up),
    .count_down_o        (count_down),
    .count_rundown_o     (count_rundown),
    .rundown_sign_o      (rundown_sign),
    .timeout_o           (timeout),
    .monitor_o           (monitor)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic build(input int mode, input int flip);
    for (int t = 0; t < 512; t++) begin
      case (mode)
        M_STEP7: comp_arr[t] = (t >= E_RD + 7);
        M_ALT:   comp_arr[t] = (t < 2) ? 1'b0 : bit'(((t + 3 - RESET_N) / CYCLE_N) % 2);
        M_STUCK: comp_arr[t] = 1'b1;
        default: begin
          if (t <= E_RD - 3) comp_arr[t] = bit'($urandom_range(0, 1));
          else if (t - (E_RD - 3) <= flip) comp_arr[t] = comp_arr[E_RD - 3];
          else comp_arr[t] = ~comp_arr[E_RD - 3];
        end
      endcase
    end
  endtask

  // A decision made at edge t sees what was driven after edge t-3
  // (two synchroniser flops plus the state register).
  task automatic model();
    m_up = 0;
    m_dn = 0;
    for (int k = 0; k < NCYC; k++) begin
      dec[k] = comp_arr[RESET_N + k * CYCLE_N - 3];
      if (dec[k]) m_dn++;
      else m_up++;
    end
    m_ref = comp_arr[E_RD - 3];
    m_rd  = 0;
    m_to  = 1'b0;
    m_x   = E_RD + 1;
    while (comp_arr[m_x - 3] == m_ref && !m_to) begin
      m_rd++;
      if (m_rd == RUNDOWN_MAX) m_to = 1'b1;
      else m_x++;
    end
  endtask

  // {int_reset, sig_sw, refmux, monitor, done} just after edge t.
  function automatic logic [6:0] exp_trace(input int t);
    logic ru, rd;
    logic [1:0] rm;
    ru = (t >= RESET_N) && (t < E_RD);
    rd = (t >= E_RD) && (t < m_x);
    rm = 2'b00;
    if (ru) rm = dec[(t - RESET_N) / CYCLE_N] ? 2'b10 : 2'b01;
    else if (rd) rm = m_ref ? 2'b10 : 2'b01;
    return {(t < RESET_N) || (t > m_x), ru, rm, rd, ru, (t == m_x + 1)};
  endfunction

  task automatic run(input string name, input int mode, input int flip,
                     input int extra_t, input bit done_start);
    int dones;
    build(mode, flip);
    model();
    dones = 0;
    @(posedge clk); #1;
    start = 1'b1;
    comp  = comp_arr[0];
    for (int t = 0; t <= m_x + 10; t++) begin
      @(posedge clk); #1;
      start = (t == extra_t) || (done_start && (t == m_x));
      comp  = comp_arr[t];
      check($sformatf("%s trace t=%0d", name, t),
            {int_reset, sig_sw, refmux, monitor, done}, exp_trace(t));
      if (done) dones++;
    end
    start = 1'b0;
    check({name, " done_pulses"},   dones, 1);
    check({name, " count_up"},      count_up, m_up);
    check({name, " count_down"},    count_down, m_dn);
    check({name, " count_rundown"}, count_rundown, m_rd);
    check({name, " rundown_sign"},  rundown_sign, m_ref);
    check({name, " timeout"},       timeout, m_to);
  endtask

  initial begin
    int dones;
    repeat (3) @(posedge clk);
    #1;
    check("reset switches", {int_reset, sig_sw, refmux, monitor, done}, 7'b1000000);
    check("reset counts", {count_up, count_down, count_rundown, rundown_sign, timeout}, 66'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    run("step7", M_STEP7, 0, -1, 1'b0);
    check("step7 up10", count_up, 10);
    check("step7 rd9", count_rundown, 9);
    run("alt", M_ALT, 0, -1, 1'b0);
    check("alt up5", count_up, 5);
    check("alt dn5", count_down, 5);
    run("stuck", M_STUCK, 0, -1, 1'b0);
    check("stuck rd50", count_rundown, RUNDOWN_MAX);
    check("stuck timeout", timeout, 1);
    run("restart", M_STEP7, 0, 50, 1'b1);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      run($sformatf("rand%0d", i), M_RAND, $urandom_range(0, 60),
          ($urandom_range(0, 1) != 0) ? $urandom_range(6, 100) : -1,
          $urandom_range(0, 1) != 0);
    end

    // Abandon a conversion mid run-up with reset.
    build(M_RAND, 20);
    @(posedge clk); #1;
    start = 1'b1;
    for (int t = 0; t <= 50; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      comp  = comp_arr[t];
    end
    check("pre-reset sig_sw", sig_sw, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset switches", {int_reset, sig_sw, refmux, monitor, done}, 7'b1000000);
    check("midreset counts", {count_up, count_down, count_rundown, rundown_sign, timeout}, 66'd0);
    reset = 1'b0;
    dones = 0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (done || !int_reset || sig_sw || refmux != 2'b00) dones++;
    end
    check("post-reset idle", dones, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
